// File: rtl/debug_latch_serializer.sv
// debug_latch_serializer
//   Takes the one-cycle request-select pulse from the debug interface, decodes
//   it and streams the selected MIPS state back as 32-bit frames (MSB word
//   first) on consecutive cycles, followed by a single end-of-data pulse.
//
// Ports
//   i_clock, i_reset          clock, asynchronous active-low reset
//   i_request_select          request code (all-ones = no request)
//   o_reg_addr                register-file debug read address (= select[4:0])
//   i_reg_data                register-file read data (valid 1 cycle after addr)
//   i_mem_data, i_instr_data  memory read data (valid 1 cycle after request)
//   i_pc                      current PC
//   i_latch_*_data/_ctrl      96-bit pipeline latch strips
//   o_frame_to_interface      streamed word (zero when not sending)
//   o_eod                     end-of-data pulse, one cycle
//   o_busy                    high whenever the FSM is not idle
//   o_state                   FSM state, for observation only
//
// Handshake: there is no valid/ready pair here. A request is a one-cycle
// pulse that is accepted only when the FSM is idle; while busy every code is
// dropped (no queueing, no backpressure). The consumer takes each frame in
// the cycle it is presented and treats o_eod as the end of the transfer.
module debug_latch_serializer #(
    parameter int NB_DATA     = 32,
    parameter int NB_LATCH    = 96,
    parameter int NB_SELECT   = 6,
    parameter int NB_REG_ADDR = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic [NB_SELECT-1:0]   i_request_select,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_DATA-1:0]     i_reg_data,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic [NB_DATA-1:0]     i_instr_data,
    input  logic [NB_DATA-1:0]     i_pc,
    input  logic [NB_LATCH-1:0]    i_latch_fetch_data,
    input  logic [NB_LATCH-1:0]    i_latch_fetch_ctrl,
    input  logic [NB_LATCH-1:0]    i_latch_deco_data,
    input  logic [NB_LATCH-1:0]    i_latch_deco_ctrl,
    input  logic [NB_LATCH-1:0]    i_latch_exec_data,
    input  logic [NB_LATCH-1:0]    i_latch_exec_ctrl,
    input  logic [NB_LATCH-1:0]    i_latch_mem_data,
    input  logic [NB_LATCH-1:0]    i_latch_mem_ctrl,
    output logic [NB_DATA-1:0]     o_frame_to_interface,
    output logic                   o_eod,
    output logic                   o_busy,
    output logic [1:0]             o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_EOD  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_REG   = 3'd0,
        SRC_DMEM  = 3'd1,
        SRC_IMEM  = 3'd2,
        SRC_PC    = 3'd3,
        SRC_LATCH = 3'd4
    } src_t;

    state_t               state, state_next;
    src_t                 src, req_src;
    logic [1:0]           cnt;
    logic [1:0]           cnt_last;
    logic [NB_LATCH-1:0]  snapshot;
    logic [NB_LATCH-1:0]  req_strip;
    logic                 req_valid;
    logic                 req_none;
    logic [NB_DATA-1:0]   snap_word;

    assign o_reg_addr = i_request_select[NB_REG_ADDR-1:0];
    assign o_busy     = (state != ST_IDLE);
    assign o_state    = state;

    // Request decode. req_strip is only meaningful when req_src is SRC_LATCH.
    always_comb begin
        req_valid = 1'b0;
        req_src   = SRC_REG;
        req_strip = '0;
        req_none  = &i_request_select;
        if (!i_request_select[NB_SELECT-1]) begin
            req_valid = 1'b1;
            req_src   = SRC_REG;
        end else begin
            case (i_request_select[4:0])
                5'b00000: begin req_valid = 1'b1; req_src = SRC_DMEM; end
                5'b00001: begin req_valid = 1'b1; req_src = SRC_IMEM; end
                5'b00010: begin req_valid = 1'b1; req_src = SRC_PC;   end
                5'b00100: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_fetch_data; end
                5'b00101: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_fetch_ctrl; end
                5'b00110: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_deco_data;  end
                5'b00111: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_deco_ctrl;  end
                5'b01000: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_exec_data;  end
                5'b01001: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_exec_ctrl;  end
                5'b01010: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_mem_data;   end
                5'b01011: begin req_valid = 1'b1; req_src = SRC_LATCH; req_strip = i_latch_mem_ctrl;   end
                default:  begin req_valid = 1'b0; end
            endcase
        end
    end

    // Latch strips are three words; every other source is one word.
    assign cnt_last = (src == SRC_LATCH) ? 2'd2 : 2'd0;

    // The PC is stored in the top word so both snapshot sources share the
    // same MSB-first word selection.
    always_comb begin
        case (cnt)
            2'd0:    snap_word = snapshot[NB_LATCH-1 -: NB_DATA];
            2'd1:    snap_word = snapshot[NB_LATCH-1-NB_DATA -: NB_DATA];
            default: snap_word = snapshot[NB_LATCH-1-2*NB_DATA -: NB_DATA];
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= ST_IDLE;
            src      <= SRC_REG;
            cnt      <= 2'd0;
            snapshot <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && req_valid) begin
                src <= req_src;
                cnt <= 2'd0;
                if (req_src == SRC_LATCH) begin
                    snapshot <= req_strip;
                end else if (req_src == SRC_PC) begin
                    snapshot <= {i_pc, {(NB_LATCH-NB_DATA){1'b0}}};
                end
            end else if (state == ST_SEND) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_next           = state;
        o_frame_to_interface = '0;
        o_eod                = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next = ST_SEND;
                end else if (!req_none) begin
                    // Unknown code: answer with an empty transfer.
                    state_next = ST_EOD;
                end
            end
            ST_SEND: begin
                case (src)
                    SRC_REG:  o_frame_to_interface = i_reg_data;
                    SRC_DMEM: o_frame_to_interface = i_mem_data;
                    SRC_IMEM: o_frame_to_interface = i_instr_data;
                    default:  o_frame_to_interface = snap_word;
                endcase
                if (cnt == cnt_last) begin
                    state_next = ST_EOD;
                end
            end
            ST_EOD: begin
                o_eod      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_debug_latch_serializer.sv
module tb_debug_latch_serializer;

    localparam int NB_DATA     = 32;
    localparam int NB_LATCH    = 96;
    localparam int NB_SELECT   = 6;
    localparam int NB_REG_ADDR = 5;
    localparam logic [5:0] NO_REQ = 6'b111111;

    logic                   i_clock;
    logic                   i_reset;
    logic [NB_SELECT-1:0]   i_request_select;
    logic [NB_REG_ADDR-1:0] o_reg_addr;
    logic [NB_DATA-1:0]     i_reg_data;
    logic [NB_DATA-1:0]     i_mem_data;
    logic [NB_DATA-1:0]     i_instr_data;
    logic [NB_DATA-1:0]     i_pc;
    logic [NB_LATCH-1:0]    i_latch_fetch_data, i_latch_fetch_ctrl;
    logic [NB_LATCH-1:0]    i_latch_deco_data,  i_latch_deco_ctrl;
    logic [NB_LATCH-1:0]    i_latch_exec_data,  i_latch_exec_ctrl;
    logic [NB_LATCH-1:0]    i_latch_mem_data,   i_latch_mem_ctrl;
    logic [NB_DATA-1:0]     o_frame_to_interface;
    logic                   o_eod;
    logic                   o_busy;
    logic [1:0]             o_state;

    int checks = 0;
    int errors = 0;

    debug_latch_serializer #(
        .NB_DATA(NB_DATA), .NB_LATCH(NB_LATCH),
        .NB_SELECT(NB_SELECT), .NB_REG_ADDR(NB_REG_ADDR)
    ) dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_request_select(i_request_select),
        .o_reg_addr(o_reg_addr),
        .i_reg_data(i_reg_data),
        .i_mem_data(i_mem_data),
        .i_instr_data(i_instr_data),
        .i_pc(i_pc),
        .i_latch_fetch_data(i_latch_fetch_data),
        .i_latch_fetch_ctrl(i_latch_fetch_ctrl),
        .i_latch_deco_data(i_latch_deco_data),
        .i_latch_deco_ctrl(i_latch_deco_ctrl),
        .i_latch_exec_data(i_latch_exec_data),
        .i_latch_exec_ctrl(i_latch_exec_ctrl),
        .i_latch_mem_data(i_latch_mem_data),
        .i_latch_mem_ctrl(i_latch_mem_ctrl),
        .o_frame_to_interface(o_frame_to_interface),
        .o_eod(o_eod),
        .o_busy(o_busy),
        .o_state(o_state)
    );

    // Clock / reset
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge; all checks and
    // input changes happen there.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Checks frame, eod and busy together for one cycle.
    task automatic check_out(input string tag, input logic [31:0] frame,
                             input logic eod, input logic busy);
        check({tag, "_frame"}, o_frame_to_interface, frame);
        check({tag, "_eod"},   {31'd0, o_eod},  {31'd0, eod});
        check({tag, "_busy"},  {31'd0, o_busy}, {31'd0, busy});
    endtask

    initial begin
        i_reset            = 1'b0;
        i_request_select   = NO_REQ;
        i_reg_data         = '0;
        i_mem_data         = '0;
        i_instr_data       = '0;
        i_pc               = '0;
        i_latch_fetch_data = '0; i_latch_fetch_ctrl = '0;
        i_latch_deco_data  = '0; i_latch_deco_ctrl  = '0;
        i_latch_exec_data  = '0; i_latch_exec_ctrl  = '0;
        i_latch_mem_data   = '0; i_latch_mem_ctrl   = '0;

        // Reset state
        #12;
        check_out("reset", 32'h0, 1'b0, 1'b0);
        tick();
        i_reset = 1'b1;
        tick();
        check_out("idle", 32'h0, 1'b0, 1'b0);

        // Fetch data strip, strip changes after T
        i_latch_fetch_data = 96'h111111112222222233333333;
        i_request_select   = 6'b100100;
        check("fetch_T_busy", {31'd0, o_busy}, 32'd0);
        tick();                                     // T+1
        i_request_select   = NO_REQ;
        i_latch_fetch_data = 96'hAAAAAAAABBBBBBBBCCCCCCCC;
        check_out("fetch_w0", 32'h11111111, 1'b0, 1'b1);
        tick();
        check_out("fetch_w1", 32'h22222222, 1'b0, 1'b1);
        tick();
        check_out("fetch_w2", 32'h33333333, 1'b0, 1'b1);
        tick();
        check_out("fetch_eod", 32'h0, 1'b1, 1'b1);
        tick();
        check_out("fetch_after", 32'h0, 1'b0, 1'b0);

        // Register read
        i_request_select = 6'b000101;
        #1;
        check("reg_addr", {27'd0, o_reg_addr}, 32'd5);
        tick();
        i_request_select = NO_REQ;
        i_reg_data       = 32'hDEADBEEF;
        #1;
        check_out("reg_w0", 32'hDEADBEEF, 1'b0, 1'b1);
        tick();
        i_reg_data = 32'h0;
        check_out("reg_eod", 32'h0, 1'b1, 1'b1);
        tick();

        // Data memory read
        i_request_select = 6'b100000;
        tick();
        i_request_select = NO_REQ;
        i_mem_data       = 32'h000000A5;
        #1;
        check_out("dmem_w0", 32'h000000A5, 1'b0, 1'b1);
        tick();
        check_out("dmem_eod", 32'h0, 1'b1, 1'b1);
        tick();

        // Instruction memory read, issued in the first idle cycle after EOD
        i_request_select = 6'b100001;
        tick();
        i_request_select = NO_REQ;
        i_instr_data     = 32'h20010003;
        #1;
        check_out("imem_w0", 32'h20010003, 1'b0, 1'b1);
        tick();
        check_out("imem_eod", 32'h0, 1'b1, 1'b1);
        tick();

        // Invalid code: empty transfer
        i_request_select = 6'b101111;
        #1;
        check("inv_T_busy", {31'd0, o_busy}, 32'd0);
        tick();
        i_request_select = NO_REQ;
        check_out("inv_eod", 32'h0, 1'b1, 1'b1);
        tick();
        check_out("inv_after", 32'h0, 1'b0, 1'b0);

        // Mem ctrl strip with a second request while busy
        i_latch_mem_ctrl = 96'h0123456789ABCDEFFEDCBA98;
        i_request_select = 6'b101011;
        tick();                                     // T+1
        i_request_select = NO_REQ;
        i_latch_mem_ctrl = 96'h0;
        check_out("mctl_w0", 32'h01234567, 1'b0, 1'b1);
        tick();                                     // T+2
        i_request_select = 6'b100010;
        i_pc             = 32'h00000999;
        check_out("mctl_w1", 32'h89ABCDEF, 1'b0, 1'b1);
        tick();                                     // T+3
        i_request_select = NO_REQ;
        check_out("mctl_w2", 32'hFEDCBA98, 1'b0, 1'b1);
        tick();                                     // T+4
        check_out("mctl_eod", 32'h0, 1'b1, 1'b1);
        tick();                                     // T+5
        check_out("mctl_idle", 32'h0, 1'b0, 1'b0);
        check("mctl_state", {30'd0, o_state}, 32'd0);
        tick();
        check_out("mctl_idle2", 32'h0, 1'b0, 1'b0);

        // Deco ctrl strip, then async reset in the middle of it
        i_latch_deco_ctrl = 96'hCAFEF00D_12345678_9ABCDEF0;
        i_request_select  = 6'b100111;
        tick();
        i_request_select  = NO_REQ;
        check_out("deco_w0", 32'hCAFEF00D, 1'b0, 1'b1);
        #3;
        i_reset = 1'b0;
        #1;
        check_out("rst_mid", 32'h0, 1'b0, 1'b0);
        tick();
        check_out("rst_hold", 32'h0, 1'b0, 1'b0);
        #2;
        i_reset = 1'b1;
        tick();
        check_out("rst_no_eod", 32'h0, 1'b0, 1'b0);

        // PC request after reset
        i_pc             = 32'h00000040;
        i_request_select = 6'b100010;
        tick();
        i_request_select = NO_REQ;
        i_pc             = 32'h00000044;
        check_out("pc_w0", 32'h00000040, 1'b0, 1'b1);
        tick();
        check_out("pc_eod", 32'h0, 1'b1, 1'b1);
        tick();
        check_out("pc_after", 32'h0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_latch_serializer.md
Name: debug_latch_serializer

Overview:
Downstream consumer of the MicroBlaze debug interface's one-cycle request-select pulse. Decodes the 6-bit select and snapshots the chosen MIPS state: a pipeline latch strip, the PC, a register-file read, or a data/instruction memory read. Streams the result as 32-bit frames on consecutive cycles, MSB word first, then pulses end-of-data. Its frame and EOD outputs feed the interface's capture buffer directly.

Parameters:
NB_DATA, 32, frame/word width
NB_LATCH, 96, width of every latch strip input (= 3 words)
NB_SELECT, 6, request-select width
NB_REG_ADDR, 5, register-file address width

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_request_select  in  NB_SELECT  one-cycle request code; all-ones = no request
o_reg_addr  out  NB_REG_ADDR  register-file debug read address
i_reg_data  in  NB_DATA  register-file read data, synchronous read (valid 1 cycle after address)
i_mem_data  in  NB_DATA  data-memory read data, valid 1 cycle after request
i_instr_data  in  NB_DATA  instruction-memory read data, valid 1 cycle after request
i_pc  in  NB_DATA  current PC
i_latch_fetch_data, i_latch_fetch_ctrl  in  NB_LATCH  IF/ID strips
i_latch_deco_data, i_latch_deco_ctrl  in  NB_LATCH  ID/EX strips
i_latch_exec_data, i_latch_exec_ctrl  in  NB_LATCH  EX/MEM strips
i_latch_mem_data, i_latch_mem_ctrl  in  NB_LATCH  MEM/WB strips
o_frame_to_interface  out  NB_DATA  streamed word
o_eod  out  1  end-of-data pulse
o_busy  out  1  high outside IDLE

Behaviour:
- Reset (i_reset=0, async): state IDLE, o_frame_to_interface=0, o_eod=0, o_busy=0, snapshot=0, word counter=0.
- o_reg_addr = i_request_select[4:0], combinational at all times.
- Select decode:
  - 0xxxxx: register (1 word)
  - 100000: data mem (1)
  - 100001: instr mem (1)
  - 100010: PC (1)
  - 100100 / 100101: fetch data / ctrl (3)
  - 100110 / 100111: deco data / ctrl (3)
  - 101000 / 101001: exec data / ctrl (3)
  - 101010 / 101011: mem data / ctrl (3)
  - 111111: no request
  - any other code: invalid
- FSM, 3 states:
  - IDLE: o_frame=0, o_eod=0.
    - Valid code at cycle T: latch source id and word count. Latch sources: snapshot the full 96-bit strip at T. PC: snapshot i_pc at T. Reg/mem sources are not snapshotted. Counter=0, go to SEND.
    - Invalid code: go to EOD directly (zero words).
  - SEND: word k is on o_frame during cycle T+1+k.
    - Latch sources: word k = snapshot[NB_LATCH-1-32k -: 32].
    - PC: the snapshot.
    - Register / data mem / instr mem: i_reg_data / i_mem_data / i_instr_data passed through combinationally at T+1.
    - Counter increments each cycle. When counter == words-1, go to EOD.
  - EOD: o_eod=1 and o_frame=0 for exactly one cycle, then IDLE.
- Timing: single-word request has eod at T+2; 3-word request has eod at T+4. No request accepted in the EOD cycle; earliest next accept is the cycle after EOD.
- Coherence: the snapshot is frozen at T. Pipeline activity after T (continuous mode) does not alter streamed words.
- i_request_select is ignored while not IDLE. No queueing, no error flag.
- Async reset mid-stream: immediately IDLE with outputs zeroed, and no EOD is emitted. The interface is reset by the same event.

Test Plan:
- Reset low mid-SEND of a 3-word latch stream -> o_frame=0, o_eod=0, o_busy=0 immediately; later request 100010 with i_pc=0x0000_0040 -> 0x0000_0040 at T+1, eod at T+2.
- Select 100100 at T with i_latch_fetch_data=0x111111112222222233333333; strip changes at T+1 -> frames 0x11111111, 0x22222222, 0x33333333 at T+1..T+3, o_eod at T+4, o_frame=0 there.
- Select 000101 at T -> o_reg_addr=5 at T; bench returns i_reg_data=0xDEADBEEF at T+1 -> frame 0xDEADBEEF at T+1, o_eod at T+2.
- Select 100000, i_mem_data=0x0000_00A5 at T+1 -> single frame 0xA5, eod T+2. Select 100001, i_instr_data=0x2001_0003 at T+1 -> single frame 0x2001_0003, eod T+2.
- Select 101111 (invalid) at T -> no frames, o_eod=1 at T+1, busy only at T+1.
- Select 101011 at T, second select 100010 at T+2 -> second ignored; 3 mem-ctrl words then eod at T+4, back in IDLE at T+5.
